// File: rtl/sram_like_ram_if.sv
// Signal bundle for the sram-like request/response bus.
// The master drives requests; the slave (memory) returns addr_ok/data_ok.
interface sram_like_ram_if;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        addr_ok;
    logic        data_ok;

    modport master (
        output req, wr, size, addr, wdata,
        input  rdata, addr_ok, data_ok
    );

    modport slave (
        input  req, wr, size, addr, wdata,
        output rdata, addr_ok, data_ok
    );
endinterface

// File: rtl/sram_like_ram.sv
// Fixed-latency sram-like responder: accesses commit to a byte-writable word RAM
// at accept, and responses travel through a LATENCY-deep shift pipe in order.
module sram_like_ram #(
    parameter int unsigned ADDR_WIDTH    = 14,
    parameter int unsigned LATENCY       = 2,
    parameter int unsigned DEPTH         = 4,
    parameter logic [15:0] STALL_PATTERN = 16'hFFFF
) (
    input logic            clk,
    input logic            rst,
    sram_like_ram_if.slave bus
);
    localparam int unsigned Words    = 2 ** ADDR_WIDTH;
    localparam logic [3:0]  DepthCnt = 4'(DEPTH);

    logic [31:0]           mem [Words];
    logic [3:0]            ptr_q, ptr_d;
    logic [3:0]            outstanding_q, outstanding_d;
    logic [LATENCY-1:0]    valid_q, valid_d;
    logic [31:0]           data_q [LATENCY];
    logic [31:0]           data_d [LATENCY];
    logic [ADDR_WIDTH-1:0] idx;
    logic [3:0]            byte_mask;
    logic                  accept;
    logic                  retire;
    logic                  unused_addr;

    // Upper address bits alias onto the same words.
    assign idx         = bus.addr[ADDR_WIDTH+1:2];
    assign unused_addr = ^bus.addr[31:ADDR_WIDTH+2];

    assign retire      = valid_q[LATENCY-1];
    assign bus.addr_ok = !rst && STALL_PATTERN[ptr_q] && ((outstanding_q < DepthCnt) || retire);
    assign accept      = bus.req && bus.addr_ok;
    assign bus.data_ok = retire;
    assign bus.rdata   = retire ? data_q[LATENCY-1] : 32'h0;

    always_comb begin
        byte_mask = 4'hF;
        case (bus.size)
            2'd0:    byte_mask = 4'b0001 << bus.addr[1:0];
            2'd1:    byte_mask = bus.addr[1] ? 4'b1100 : 4'b0011;
            default: byte_mask = 4'hF;
        endcase
    end

    always_ff @(posedge clk) begin
        if (accept && bus.wr) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_mask[i]) begin
                    mem[idx][8*i +: 8] <= bus.wdata[8*i +: 8];
                end
            end
        end
    end

    always_comb begin
        ptr_d      = ptr_q + 4'd1;
        valid_d[0] = accept;
        // Reads see the pre-edge RAM word, which already holds every earlier write.
        data_d[0]  = (accept && !bus.wr) ? mem[idx] : 32'h0;
        for (int i = 1; i < int'(LATENCY); i++) begin
            valid_d[i] = valid_q[i-1];
            data_d[i]  = data_q[i-1];
        end

        outstanding_d = outstanding_q;
        if (accept && !retire) begin
            outstanding_d = outstanding_q + 4'd1;
        end else if (!accept && retire) begin
            outstanding_d = outstanding_q - 4'd1;
        end

        if (rst) begin
            ptr_d         = '0;
            outstanding_d = '0;
            valid_d       = '0;
        end
    end

    always_ff @(posedge clk) begin
        ptr_q         <= ptr_d;
        outstanding_q <= outstanding_d;
        valid_q       <= valid_d;
        data_q        <= data_d;
    end
endmodule

// File: tb/tb_sram_like_ram.sv
// Scoreboard bench for sram_like_ram: three instances cover the default-style pipe,
// a depth-1 throttled pipe and a stall-patterned port.
module tb_sram_like_ram;
    localparam int unsigned LatM = 4;
    localparam int unsigned LatD = 2;

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sram_like_ram_if m_if ();
    sram_like_ram_if d_if ();
    sram_like_ram_if s_if ();

    sram_like_ram #(.LATENCY(LatM), .DEPTH(4)) u_main (
        .clk(clk), .rst(rst), .bus(m_if.slave)
    );
    sram_like_ram #(.LATENCY(LatD), .DEPTH(1)) u_d1 (
        .clk(clk), .rst(rst), .bus(d_if.slave)
    );
    sram_like_ram #(.LATENCY(1), .DEPTH(4), .STALL_PATTERN(16'hAAAA)) u_stall (
        .clk(clk), .rst(rst), .bus(s_if.slave)
    );

    int         n_checks = 0;
    int         n_fails  = 0;
    int         cyc      = 0;
    logic [3:0] ptr_m    = 4'd0;
    exp_t       q_main[$];
    exp_t       q_d1[$];
    exp_t       e_m;
    exp_t       e_d;
    int         d1_strobes = 0;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        ptr_m <= rst ? 4'd0 : ptr_m + 4'd1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: actual %h required %h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Main scoreboard monitor: every strobe must match the oldest pending entry.
    always @(negedge clk) begin
        if (m_if.data_ok) begin
            check("main_resp_pending", 32'(q_main.size() != 0), 32'd1);
            if (q_main.size() != 0) begin
                e_m = q_main.pop_front();
                check("main_rdata", m_if.rdata, e_m.data);
                check("main_latency", 32'(cyc), 32'(e_m.cyc));
            end
        end else begin
            check("main_rdata_idle_zero", m_if.rdata, 32'h0);
        end
    end

    always @(negedge clk) begin
        if (d_if.data_ok) begin
            d1_strobes++;
            check("d1_resp_pending", 32'(q_d1.size() != 0), 32'd1);
            if (q_d1.size() != 0) begin
                e_d = q_d1.pop_front();
                check("d1_rdata", d_if.rdata, e_d.data);
            end
        end
    end

    task automatic drive_main(input logic w, input logic [1:0] sz, input logic [31:0] a,
                              input logic [31:0] wd, input logic [31:0] exp_rd);
        bit done = 1'b0;
        m_if.req   = 1'b1;
        m_if.wr    = w;
        m_if.size  = sz;
        m_if.addr  = a;
        m_if.wdata = wd;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (m_if.addr_ok) begin
                q_main.push_back(exp_t'{data: exp_rd, cyc: cyc + int'(LatM)});
                done = 1'b1;
            end
        end
        check("main_accept_timeout", 32'(done), 32'd1);
        @(posedge clk);
        #1;
        m_if.req = 1'b0;
    endtask

    task automatic drain_main();
        for (int i = 0; i < 40 && q_main.size() != 0; i++) @(posedge clk);
        check("main_drained", 32'(q_main.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic set_d1(input int idx);
        d_if.wr    = (idx < 10);
        d_if.size  = 2'd2;
        d_if.addr  = 32'((idx % 10) * 4);
        d_if.wdata = 32'hA0 + 32'(idx);
    endtask

    initial begin
        int         idx;
        int         acc;
        int         cnt;
        logic       exp_ok;
        logic       prev_acc;

        m_if.req = 1'b0; m_if.wr = 1'b0; m_if.size = 2'd0; m_if.addr = '0; m_if.wdata = '0;
        d_if.req = 1'b0; d_if.wr = 1'b0; d_if.size = 2'd0; d_if.addr = '0; d_if.wdata = '0;
        s_if.req = 1'b0; s_if.wr = 1'b0; s_if.size = 2'd0; s_if.addr = '0; s_if.wdata = '0;

        @(negedge clk);
        check("rst_addr_ok_low", m_if.addr_ok, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_data_ok", m_if.data_ok, 32'd0);
        check("rst_rdata", m_if.rdata, 32'h0);
        check("rst_addr_ok_high", m_if.addr_ok, 32'd1);
        check("rst_outstanding", u_main.outstanding_q, 32'd0);
        @(posedge clk);
        #1;

        // Word write then read.
        drive_main(1'b1, 2'd2, 32'h100, 32'hDEADBEEF, 32'h0);
        drive_main(1'b0, 2'd2, 32'h100, 32'h0, 32'hDEADBEEF);
        drain_main();

        // Byte and half-word merges into one word.
        drive_main(1'b1, 2'd2, 32'h200, 32'h11223344, 32'h0);
        drive_main(1'b1, 2'd0, 32'h202, 32'h00AA0000, 32'h0);
        drive_main(1'b1, 2'd1, 32'h200, 32'h0000BBCC, 32'h0);
        drive_main(1'b0, 2'd2, 32'h200, 32'h0, 32'h11AABBCC);
        // Aliased upper bits, half write with addr[0] set, size 3 as word.
        drive_main(1'b1, 2'd2, 32'h10400, 32'hCAFEF00D, 32'h0);
        drive_main(1'b0, 2'd2, 32'h400, 32'h0, 32'hCAFEF00D);
        drive_main(1'b1, 2'd1, 32'h403, 32'h12340000, 32'h0);
        drive_main(1'b0, 2'd2, 32'h400, 32'h0, 32'h1234F00D);
        drive_main(1'b1, 2'd3, 32'h502, 32'h89ABCDEF, 32'h0);
        drive_main(1'b0, 2'd0, 32'h501, 32'h0, 32'h89ABCDEF);
        // Read-after-write on consecutive accepts.
        drive_main(1'b1, 2'd2, 32'h300, 32'h5, 32'h0);
        drive_main(1'b0, 2'd2, 32'h300, 32'h0, 32'h5);
        drain_main();

        // Depth-1 pipe with req held: one accept every other cycle.
        idx    = 0;
        exp_ok = 1'b1;
        set_d1(0);
        d_if.req = 1'b1;
        for (int c = 0; c < 100 && idx < 20; c++) begin
            @(negedge clk);
            check("d1_addr_ok_alternates", d_if.addr_ok, 32'(exp_ok));
            check("d1_outstanding_le_1", 32'(u_d1.outstanding_q <= 4'd1), 32'd1);
            exp_ok = !exp_ok;
            if (d_if.addr_ok) begin
                q_d1.push_back(exp_t'{data: (idx < 10) ? 32'h0 : 32'hA0 + 32'(idx - 10), cyc: 0});
                idx++;
            end
            @(posedge clk);
            #1;
            if (idx < 20) set_d1(idx);
            else d_if.req = 1'b0;
        end
        d_if.req = 1'b0;
        check("d1_accepts", 32'(idx), 32'd20);
        for (int i = 0; i < 20 && q_d1.size() != 0; i++) @(posedge clk);
        check("d1_drained", 32'(q_d1.size()), 32'd0);
        check("d1_strobes", 32'(d1_strobes), 32'd20);
        @(posedge clk);
        #1;

        // Stall pattern 0xAAAA: accepts only on odd ptr.
        s_if.req  = 1'b1;
        s_if.size = 2'd2;
        prev_acc  = 1'b0;
        acc       = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            check("stall_addr_ok_vs_ptr", s_if.addr_ok, 32'(ptr_m[0]));
            check("stall_data_ok_next_cycle", s_if.data_ok, 32'(prev_acc));
            prev_acc = s_if.addr_ok;
            acc += int'(s_if.addr_ok);
        end
        @(posedge clk);
        #1;
        s_if.req = 1'b0;
        check("stall_accept_count", 32'(acc), 32'd10);
        @(posedge clk);
        #1;

        // Reset with three reads in flight: responses are dropped, RAM survives.
        drive_main(1'b0, 2'd2, 32'h100, 32'h0, 32'h0);
        drive_main(1'b0, 2'd2, 32'h200, 32'h0, 32'h0);
        drive_main(1'b0, 2'd2, 32'h300, 32'h0, 32'h0);
        rst = 1'b1;
        q_main.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst6_outstanding", u_main.outstanding_q, 32'd0);
        cnt = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            cnt += int'(m_if.data_ok);
        end
        check("rst6_no_data_ok", 32'(cnt), 32'd0);
        @(posedge clk);
        #1;
        drive_main(1'b0, 2'd2, 32'h100, 32'h0, 32'hDEADBEEF);
        drive_main(1'b0, 2'd2, 32'h300, 32'h0, 32'h5);
        drain_main();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish at t=%0t", $time);
        $fatal(1, "timeout");
    end
endmodule
